// File: rtl/fsm_fifo_sha3_unpack.sv
// Reassembles 256-bit SHA3 hashes from four 64-bit reads of a standard-mode FIFO.
// Double-buffered: one hash can wait in the assembly register while another is held on the output.
module fsm_fifo_sha3_unpack #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   input  logic [63:0]      fifo_dout,
   output logic             fifo_re,
   output logic [255:0]     hash_out,
   output logic             hash_valid,
   input  logic             hash_ready,
   output logic [CNT_W-1:0] hash_count
);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_LAST = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t           r_state;
   logic [2:0]       r_rd_cnt;
   logic [1:0]       r_cap_idx;
   logic             r_rd_pending;
   logic [191:0]     r_asm;
   logic [63:0]      r_asm_hi;
   logic             r_asm_full;
   logic [255:0]     r_hash_out;
   logic             r_hash_valid;
   logic [CNT_W-1:0] r_hash_count;

   logic w_re;
   logic w_hs;
   logic w_out_free;

   // Read enable must follow fifo_empty in the same cycle, so it cannot be registered.
   assign w_re       = !rst && (r_state == S_FILL) && (r_rd_cnt < 3'd4) && !fifo_empty;
   assign w_hs       = r_hash_valid && hash_ready;
   assign w_out_free = !r_hash_valid || hash_ready;

   assign fifo_re    = w_re;
   assign hash_out   = r_hash_out;
   assign hash_valid = r_hash_valid;
   assign hash_count = r_hash_count;

   // Sequencer, capture datapath and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_FILL;
         r_rd_cnt     <= 3'd0;
         r_cap_idx    <= 2'd0;
         r_rd_pending <= 1'b0;
         r_asm        <= 192'd0;
         r_asm_hi     <= 64'd0;
         r_asm_full   <= 1'b0;
         r_hash_out   <= 256'd0;
         r_hash_valid <= 1'b0;
         r_hash_count <= {CNT_W{1'b0}};
      end else begin
         r_rd_pending <= w_re;
         if (w_hs) begin
            r_hash_count <= r_hash_count + {{(CNT_W-1){1'b0}}, 1'b1};
            r_hash_valid <= 1'b0;
         end
         // Data lands one cycle after its read; a load below overrides cap_idx.
         if (r_rd_pending && (r_state != S_HOLD)) begin
            case (r_cap_idx)
               2'd0:    r_asm[63:0]    <= fifo_dout;
               2'd1:    r_asm[127:64]  <= fifo_dout;
               2'd2:    r_asm[191:128] <= fifo_dout;
               2'd3:    r_asm_hi       <= fifo_dout;
               default: r_asm_hi       <= fifo_dout;
            endcase
            r_cap_idx <= r_cap_idx + 2'd1;
         end
         case (r_state)
            S_FILL: begin
               if (w_re) begin
                  r_rd_cnt <= r_rd_cnt + 3'd1;
                  if (r_rd_cnt == 3'd3) begin
                     r_state <= S_LAST;
                  end
               end
            end
            S_LAST: begin
               if (w_out_free) begin
                  r_hash_out   <= {fifo_dout, r_asm};
                  r_hash_valid <= 1'b1;
                  r_rd_cnt     <= 3'd0;
                  r_cap_idx    <= 2'd0;
                  r_state      <= S_FILL;
               end else begin
                  r_asm_full <= 1'b1;
                  r_state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_hs && r_asm_full) begin
                  r_hash_out   <= {r_asm_hi, r_asm};
                  r_hash_valid <= 1'b1;
                  r_asm_full   <= 1'b0;
                  r_rd_cnt     <= 3'd0;
                  r_cap_idx    <= 2'd0;
                  r_state      <= S_FILL;
               end
            end
            default: begin
               r_state <= S_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_fifo_sha3_unpack.sv
// Randomised bench for fsm_fifo_sha3_unpack: FIFO model, transaction-level reference, per-cycle compare.
// A second instance with a 2-bit counter exercises the hash_count wrap.
module tb_fsm_fifo_sha3_unpack;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fifo_empty = 1'b1;
   logic [63:0]   fifo_dout = 64'd0;
   logic          hash_ready = 1'b0;
   logic          fifo_re, fifo_re2;
   logic [255:0]  hash_out, hash_out2;
   logic          hash_valid, hash_valid2;
   logic [31:0]   hash_count;
   logic [1:0]    hash_count2;

   always #5 clk = ~clk;

   fsm_fifo_sha3_unpack #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(fifo_re),
      .hash_out(hash_out), .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_count(hash_count)
   );

   fsm_fifo_sha3_unpack #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_re(fifo_re2),
      .hash_out(hash_out2), .hash_valid(hash_valid2), .hash_ready(hash_ready), .hash_count(hash_count2)
   );

   // Standard-mode FIFO: data appears the cycle after the read.
   logic [63:0] q[$];
   always @(posedge clk) begin
      if (fifo_re && q.size() > 0) fifo_dout <= q.pop_front();
   end

   // Reference model state (transaction level).
   int           m_issued = 0;
   logic [63:0]  m_words[$];
   logic         m_pending = 1'b0;
   logic         m_valid = 1'b0;
   logic         m_held_full = 1'b0;
   logic [255:0] m_held = '0;
   logic [255:0] m_out = '0;
   logic [31:0]  m_count = 32'd0;
   logic         e_re = 1'b0;
   // Inputs as seen at the previous rising edge.
   logic         s_rst = 1'b1, s_ready = 1'b0, s_re = 1'b0;
   logic [63:0]  s_dout = 64'd0;

   int n_pass = 0, n_tot = 0, cyc = 0;
   logic [63:0]  exp_w[$];
   logic [255:0] hs_q[$];
   int           vcyc[$];
   logic [1:0]   c2_q[$];
   logic [1:0]   prev_c2 = 2'd0;
   int           re_n = 0, first_re = -1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
   endtask

   function automatic logic [255:0] pack4(input logic [63:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic model_adv();
      logic hs, load;
      logic [255:0] nw;
      if (s_rst) begin
         m_issued = 0; m_words.delete(); m_pending = 1'b0; m_valid = 1'b0;
         m_held_full = 1'b0; m_out = '0; m_count = 32'd0;
      end else begin
         hs = m_valid && s_ready;
         load = 1'b0;
         nw = '0;
         if (m_held_full) begin
            if (hs) begin nw = m_held; load = 1'b1; m_held_full = 1'b0; m_issued = 0; end
         end else if (m_pending) begin
            m_words.push_back(s_dout);
            if (m_words.size() == 4) begin
               nw = pack4(m_words[0], m_words[1], m_words[2], m_words[3]);
               m_words.delete();
               if (!m_valid || s_ready) begin load = 1'b1; m_issued = 0; end
               else begin m_held = nw; m_held_full = 1'b1; end
            end
         end
         if (s_re) m_issued++;
         m_pending = s_re;
         if (load) begin m_out = nw; m_valid = 1'b1; end
         else if (hs) m_valid = 1'b0;
         if (hs) m_count++;
      end
   endtask

   // One clock cycle: advance the model, apply inputs, compare every output.
   task automatic step(input logic r, input logic rdy, input logic gp);
      @(negedge clk);
      model_adv();
      rst = r;
      hash_ready = rdy;
      if (r) q.delete();
      fifo_empty = (q.size() == 0) || gp;
      #1;
      e_re = !rst && !fifo_empty && (m_issued < 4);
      chk("fifo_re", fifo_re, e_re);
      chk("re_vs_empty", fifo_re && fifo_empty, 1'b0);
      chk("hash_valid", hash_valid, m_valid);
      chk("hash_out", hash_out, m_out);
      chk("hash_count", hash_count, m_count);
      chk("fifo_re_w2", fifo_re2, e_re);
      chk("hash_valid_w2", hash_valid2, m_valid);
      chk("hash_out_w2", hash_out2, m_out);
      chk("hash_count_w2", hash_count2, m_count[1:0]);
      s_rst = rst; s_ready = hash_ready; s_re = e_re; s_dout = fifo_dout;
      cyc++;
   endtask

   task automatic clear_logs();
      hs_q.delete(); vcyc.delete(); c2_q.delete(); re_n = 0; first_re = -1;
   endtask

   // rmode/gmode: 0 = off, 1 = on (gap: alternate), 2 = random.
   task automatic run(input int n, input int rmode, input int gmode);
      logic rdy, gp;
      for (int i = 0; i < n; i++) begin
         rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
         gp  = (gmode == 2) ? ($urandom_range(0, 3) == 0) : ((gmode == 1) && (i % 2 == 0));
         step(1'b0, rdy, gp);
         if (fifo_re) begin re_n++; if (first_re < 0) first_re = i; end
         if (hash_valid) vcyc.push_back(i);
         if (hash_valid && hash_ready) hs_q.push_back(hash_out);
         if (hash_count2 != prev_c2) begin c2_q.push_back(hash_count2); prev_c2 = hash_count2; end
      end
   endtask

   task automatic push_rand(input int n);
      logic [63:0] w;
      for (int i = 0; i < n; i++) begin
         w = {$urandom(), $urandom()};
         q.push_back(w);
         exp_w.push_back(w);
      end
   endtask

   function automatic logic [255:0] exp_hash(input int k);
      return pack4(exp_w[4*k], exp_w[4*k+1], exp_w[4*k+2], exp_w[4*k+3]);
   endfunction

   initial begin
      logic [255:0] h;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      chk("reset_valid", hash_valid, 1'b0);
      chk("reset_out", hash_out, 256'd0);
      chk("reset_count", hash_count, 32'd0);

      // Single hash with fixed words and latency.
      q.push_back(64'h1111111111111111); q.push_back(64'h2222222222222222);
      q.push_back(64'h3333333333333333); q.push_back(64'h4444444444444444);
      clear_logs();
      run(20, 1, 0);
      chk("single_re_cycles", 32'(re_n), 32'd4);
      chk("single_latency", 32'(vcyc.size() > 0 ? vcyc[0] - first_re : -1), 32'd5);
      chk("single_hash", hash_out,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
      chk("single_count", hash_count, 32'd1);

      // Back-to-back: two hashes five cycles apart.
      exp_w.delete(); clear_logs();
      push_rand(8);
      run(30, 1, 0);
      chk("b2b_pulses", 32'(vcyc.size()), 32'd2);
      chk("b2b_spacing", 32'(vcyc.size() == 2 ? vcyc[1] - vcyc[0] : -1), 32'd5);
      chk("b2b_hash0", hs_q.size() > 0 ? hs_q[0] : '0, exp_hash(0));
      chk("b2b_hash1", hs_q.size() > 1 ? hs_q[1] : '0, exp_hash(1));
      chk("b2b_count", hash_count, 32'd3);

      // Backpressure: one hash on output, one held, four words left behind.
      exp_w.delete(); clear_logs();
      push_rand(12);
      run(20, 0, 0);
      chk("bp_re_idle", fifo_re, 1'b0);
      chk("bp_fifo_left", 32'(q.size()), 32'd4);
      chk("bp_valid", hash_valid, 1'b1);
      chk("bp_out", hash_out, exp_hash(0));
      clear_logs();
      run(40, 1, 0);
      chk("bp_delivered", 32'(hs_q.size()), 32'd3);
      for (int k = 0; k < 3; k++) chk("bp_order", hs_q.size() > k ? hs_q[k] : '0, exp_hash(k));
      chk("bp_count", hash_count, 32'd6);

      // Empty gaps every other cycle.
      exp_w.delete(); clear_logs();
      push_rand(4);
      run(24, 1, 1);
      chk("gap_hash", hash_out, exp_hash(0));
      chk("gap_count", hash_count, 32'd7);

      // Reset mid-hash, then only fresh words may form the hash.
      exp_w.delete();
      push_rand(4);
      run(3, 1, 0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      chk("mid_rst_re", fifo_re, 1'b0);
      chk("mid_rst_valid", hash_valid, 1'b0);
      chk("mid_rst_out", hash_out, 256'd0);
      chk("mid_rst_count", hash_count, 32'd0);
      exp_w.delete(); clear_logs(); prev_c2 = 2'd0;
      push_rand(4);
      run(15, 1, 0);
      chk("fresh_hash", hash_out, exp_hash(0));

      // Counter wrap on the 2-bit instance.
      push_rand(16);
      run(40, 1, 0);
      chk("wrap_len", 32'(c2_q.size()), 32'd5);
      h = {c2_q.size() > 0 ? c2_q[0] : 2'd3, c2_q.size() > 1 ? c2_q[1] : 2'd3,
           c2_q.size() > 2 ? c2_q[2] : 2'd3, c2_q.size() > 3 ? c2_q[3] : 2'd3,
           c2_q.size() > 4 ? c2_q[4] : 2'd3};
      chk("wrap_seq", h, {246'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1});

      // Random readiness and gaps, then drain.
      exp_w.delete(); clear_logs();
      push_rand(40);
      run(400, 2, 2);
      run(40, 1, 0);
      chk("rand_delivered", 32'(hs_q.size()), 32'd10);
      for (int k = 0; k < 10; k++) chk("rand_order", hs_q.size() > k ? hs_q[k] : '0, exp_hash(k));
      chk("rand_fifo_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/fsm_fifo_sha3_unpack.md
# fsm_fifo_sha3_unpack

Read-side counterpart of the SHA3 hash FIFO packer. Pulls four 64-bit words per hash from a standard-mode (non-FWFT, 1-cycle read latency) FIFO, reassembles the 256-bit hash and presents it downstream with a valid/ready handshake. It is double-buffered (assembly register plus output register), so assembly of hash N+1 overlaps a stalled hand-off of hash N. It sits between the hash FIFO and the result/readout logic of the oBTC miner.

## Interface
- CNT_W, 32: width of the delivered-hash counter.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  64  FIFO read data, valid the cycle after fifo_re.
- fifo_re  out  1  FIFO read enable.
- hash_out  out  256  assembled hash; stable while hash_valid && !hash_ready.
- hash_valid  out  1  hash_out holds a hash.
- hash_ready  in  1  downstream accepts hash_out this cycle.
- hash_count  out  CNT_W  number of completed hand-offs, wraps modulo 2^CNT_W.

## Operation
- Word order: 1st FIFO word -> bits [63:0], 2nd -> [127:64], 3rd -> [191:128], 4th -> [255:192].
- Registers: rd_cnt (0..4, reads issued for the current hash), cap_idx (0..3, next slot to capture), rd_pending (a read was issued last cycle), asm[191:0], asm_full, hash_out, hash_valid, hash_count.
- FSM states:
  - FILL: rd_cnt < 4. fifo_re = !fifo_empty. On fifo_re, rd_cnt++. Go to LAST when the 4th read is issued.
  - LAST: exactly one cycle; fifo_re = 0; the 4th word is captured. If the output is free (!hash_valid || hash_ready), load hash_out = {fifo_dout, asm}, set hash_valid, reset rd_cnt/cap_idx, and go to FILL. Otherwise latch fifo_dout into the upper slot, set asm_full, and go to HOLD.
  - HOLD: fifo_re = 0. When hash_ready && hash_valid, copy asm into hash_out in that cycle, keep hash_valid = 1, clear asm_full, reset counters, and go to FILL.
- Capture: when rd_pending, fifo_dout is written to slot cap_idx and cap_idx++. This happens in FILL and LAST, and is independent of fifo_empty.
- Output: a handshake (hash_valid && hash_ready) with no new load in the same cycle clears hash_valid. A handshake and a load in the same cycle keeps hash_valid = 1 with the new data. hash_count increments on every handshake.
- fifo_empty gaps inside a hash pause issuing only; partially assembled words are retained indefinitely.
- fifo_re is never asserted when fifo_empty = 1, in LAST or HOLD, or while rst = 1.

## Timing
- Reset values: fifo_re = 0, hash_valid = 0, hash_out = 0, hash_count = 0. State is FILL with rd_cnt = 0, cap_idx = 0, rd_pending = 0, asm = 0, asm_full = 0.
- Reset mid-operation discards any partial hash and the held hash. A word read in the cycle before rst is lost; the upstream FIFO is reset together with this block.
- Latency: fifo_re in cycles T..T+3 (FIFO non-empty) gives state LAST in T+4 and hash_valid = 1 in T+5 if the output is free.
- Throughput: 1 hash per 5 cycles with continuous data and hash_ready = 1. The next hash's first fifo_re is in T+5.
- Stalled output: the assembly completes into HOLD. On the handshake cycle H, the held hash appears on hash_out in H+1, and fifo_re resumes in H+1.
- hash_ready with hash_valid = 0 has no effect. hash_out changes only on a load.

## Test plan
- Single hash: FIFO holds 64'h1111…, 64'h2222…, 64'h3333…, 64'h4444…; hash_ready = 1 -> fifo_re high for 4 cycles, hash_valid one cycle later than LAST, hash_out = {4444…, 3333…, 2222…, 1111…}, hash_count = 1.
- Back-to-back: 8 words, hash_ready = 1 -> two hashes, hash_valid pulses 5 cycles apart, hash_count = 2.
- Backpressure: 12 words, hash_ready = 0 for 20 cycles -> hash 0 on output, hash 1 in HOLD, fifo_re = 0 and 4 words left in FIFO. On release: hash 0, hash 1 and hash 2 delivered in order, no words lost, hash_count = 3.
- Empty gaps: fifo_empty toggles every other cycle within a hash -> fifo_re never asserted while empty, hash correct.
- Reset mid-hash: rst after 2 words captured, then 4 fresh words -> all outputs at reset values during rst, the first hash_out equals only the fresh words.
- Wrap: CNT_W = 2, 5 hashes -> hash_count sequence 1, 2, 3, 0, 1.
